poly1305_tag_verifier: RTL and testbench
========================================

# poly1305_tag_verifier

Receive-side Poly1305 authenticator for the ChaCha20-Poly1305 path. It takes the one-time Poly1305 key, accumulates 16-byte message blocks with a bit-serial modular multiplier, and forms the tag. It then compares that tag, in constant time, against the tag received with the ciphertext. It sits beside the decrypt datapath and gates release of plaintext through `tag_ok`.

## Interface
- No parameters. Widths are fixed by Poly1305.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `init` in 1: one-cycle strobe; loads `key`, clears the accumulator and aborts any operation in progress.
- `key` in 256: one-time key; r = `key[127:0]` (clamped internally), s = `key[255:128]`; sampled when `init` is high.
- `blk_valid` in 1: a message block is presented.
- `blk_ready` out 1: the block or the finalize request is accepted this cycle.
- `blk_data` in 128: little-endian block; byte i is `blk_data[8i+7:8i]`; bytes at or above `blk_len` must be zero.
- `blk_len` in 4: byte count of the block; 0 means 16.
- `fin` in 1: finalize request; compare against `tag_in`.
- `tag_in` in 128: received tag, little-endian; sampled when `fin` is accepted.
- `busy` out 1: high in MUL and FIN.
- `done` out 1: one-cycle pulse when `tag_out` and `tag_ok` become valid.
- `tag_ok` out 1: computed tag equals `tag_in`; holds until the next `init` or reset.
- `tag_out` out 128: computed tag (acc + s) mod 2^128; holds until the next `init` or reset.

## Operation
- **p and clamping**
  - p = 2^130−5.
  - On `init`: r = `key[127:0]` & 0x0ffffffc_0ffffffc_0ffffffc_0fffffff; s = `key[255:128]`; acc = 0.
- **States:** IDLE, LOAD, MUL, FIN.
- **IDLE** (after reset, and after FIN)
  - `blk_ready` = 0.
  - `blk_valid` and `fin` are ignored. Only `init` leaves IDLE, going to LOAD.
- **LOAD**
  - `blk_ready` = 1.
  - Block accept (`blk_valid`):
    - m = `blk_data` + 2^(8·len), where len = 16 if `blk_len` = 0.
    - a = acc + m. Since a < 2p, one conditional subtract of p gives a mod p, which is registered as the multiplicand.
    - t = 0, bit index k = 127; go to MUL.
  - `fin` is accepted only when `blk_valid` is low. On accept, `tag_in` is latched and the state goes to FIN.
  - If `blk_valid` and `fin` are high together, the block is taken and `fin` is dropped; the source re-asserts it.
- **MUL**
  - Exactly 128 steps, one per cycle, MSB-first over r[127:0]. All 128 steps run even when the top bits are zero, so latency is constant.
  - Each step:
    - t ← 2t; if t ≥ p, t ← t − p.
    - If r[k] = 1: t ← t + a; if t ≥ p, t ← t − p.
  - All intermediates are held at 131 bits. After step k = 0: acc ← t (< p); return to LOAD.
- **FIN**
  - tag = (acc + s) mod 2^128.
  - `tag_ok` = 1 iff OR-reduce(tag ^ `tag_in`) == 0. The compare is a full-width XOR/OR with no early exit.
  - Register `tag_out`, `tag_ok`, and pulse `done`, then go to IDLE. The key is consumed; a new `init` is required.
- **`init` behaviour**
  - `init` in any state has priority over `blk_valid` and `fin`.
  - `init` during MUL or FIN aborts: no `done`, `tag_ok` cleared, `tag_out` cleared.
- **Empty message:** `fin` directly after `init` gives tag = s.

## Timing
- **Reset values:** `blk_ready` 0, `busy` 0, `done` 0, `tag_ok` 0, `tag_out` 0; state IDLE; r, s, acc = 0.
- **`init`:** `init` at edge E makes `blk_ready` = 1 in the cycle after E.
- **Block accept:** block accepted at edge E0.
  - MUL occupies the cycles after E0 through E128.
  - acc is written at E128.
  - `blk_ready` = 1 again in the cycle after E128.
  - Block-to-block throughput is therefore 129 cycles.
- **Finalize:** `fin` accepted at edge F0.
  - FIN in the cycle after F0.
  - `tag_out` and `tag_ok` are registered at F1.
  - `done` is high for exactly the cycle after F1.
  - State is IDLE after F1.
- **Handshake:** `blk_ready` is a registered function of state only, with no combinational path from `blk_valid` or `fin`.

## Test plan
- **RFC 8439 §2.5.2 match.**
  - Key bytes: 85 d6 be 78 57 55 6d 33 7f 44 52 fe 42 d5 06 a8 01 03 80 8a fb 0d b2 fd 4a bf f6 af 41 49 f5 1b.
  - Message "Cryptographic Forum Research Group": two blocks of len 16 and one block of `blk_len` = 2.
  - `fin` with `tag_in` = a8 06 1d c1 30 51 36 c6 c2 2b 8b af 0c 01 27 a9.
  - Expected: `tag_out` equals `tag_in`, `tag_ok` = 1, `done` pulses 2 cycles after `fin` is accepted.
- **RFC vector, corrupted tag.** Same stimulus with bit 0 of `tag_in` flipped → `tag_out` unchanged, `tag_ok` = 0, `done` timing identical.
- **Empty message.** `init` then immediate `fin` → `tag_out` = s = 0x1bf54941aff6bf4afdb20dfb8a800301 (RFC key); `tag_ok` = 1 iff `tag_in` equals s.
- **Timing and handshake.**
  - Block accepted at E0 → `busy` = 1 and `blk_ready` = 0 through the cycle ending at E128, then `blk_ready` = 1.
  - `blk_valid` and `fin` high together → block taken, `fin` ignored.
  - `blk_valid` or `fin` in IDLE → no accept and no `done`.
- **Abort.**
  - `init` at MUL step 60 with a new key → no `done`, acc cleared.
  - Re-running the RFC vector then yields `tag_ok` = 1.
  - Asserting `reset_n` low mid-MUL → all outputs return to their reset values immediately.
- **Zero r.** Key with r = 0 and arbitrary s, three blocks → `tag_out` = s.

Source files
------------

// File: rtl/poly1305_tag_verifier.sv
// poly1305_tag_verifier
// Receive-side Poly1305 authenticator: accumulates 16-byte blocks with a
// constant-latency bit-serial modular multiplier (128 cycles per block),
// then forms the tag and compares it against the received tag in constant time.
module poly1305_tag_verifier (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic [255:0] key,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [127:0] blk_data,
    input  logic [3:0]   blk_len,
    input  logic         fin,
    input  logic [127:0] tag_in,
    output logic         busy,
    output logic         done,
    output logic         tag_ok,
    output logic [127:0] tag_out
);

    // p = 2^130 - 5, carried at 131 bits so 2t and t + a never overflow
    localparam logic [130:0] P       = 131'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;
    localparam logic [130:0] ONE     = 131'd1;
    localparam logic [127:0] R_CLAMP = 128'h0fff_fffc_0fff_fffc_0fff_fffc_0fff_ffff;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_FIN
    } state_t;

    state_t         r_state;
    logic [127:0]   r_r;
    logic [127:0]   r_s;
    logic [129:0]   r_acc;
    logic [130:0]   r_a;
    logic [130:0]   r_t;
    logic [6:0]     r_k;
    logic [127:0]   r_tag_in;
    logic           r_blk_ready;
    logic           r_busy;
    logic           r_done;
    logic           r_tag_ok;
    logic [127:0]   r_tag_out;

    logic [4:0]     w_len_bytes;
    logic [130:0]   w_pad;
    logic [130:0]   w_m;
    logic [130:0]   w_sum;
    logic [130:0]   w_a_red;
    logic [130:0]   w_dbl;
    logic [130:0]   w_dbl_red;
    logic [130:0]   w_add;
    logic [130:0]   w_add_red;
    logic [130:0]   w_t_next;
    logic [127:0]   w_tag;
    logic           w_tag_match;

    // Block absorb: m = data + 2^(8*len); acc + m < 2p so one subtract reduces it
    assign w_len_bytes = (blk_len == 4'd0) ? 5'd16 : {1'b0, blk_len};
    assign w_pad       = ONE << {w_len_bytes, 3'b000};
    assign w_m         = {3'b000, blk_data} + w_pad;
    assign w_sum       = {1'b0, r_acc} + w_m;
    assign w_a_red     = (w_sum >= P) ? (w_sum - P) : w_sum;

    // One MSB-first multiplier step: t = 2t mod p, then conditionally t = t + a mod p
    assign w_dbl       = r_t << 1;
    assign w_dbl_red   = (w_dbl >= P) ? (w_dbl - P) : w_dbl;
    assign w_add       = w_dbl_red + r_a;
    assign w_add_red   = (w_add >= P) ? (w_add - P) : w_add;
    assign w_t_next    = r_r[r_k] ? w_add_red : w_dbl_red;

    // Tag and full-width constant-time compare (no early exit)
    assign w_tag       = r_acc[127:0] + r_s;
    assign w_tag_match = ~|(w_tag ^ r_tag_in);

    // Control FSM with datapath registers and registered outputs; init has top priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_r         <= '0;
            r_s         <= '0;
            r_acc       <= '0;
            r_a         <= '0;
            r_t         <= '0;
            r_k         <= '0;
            r_tag_in    <= '0;
            r_blk_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_tag_ok    <= 1'b0;
            r_tag_out   <= '0;
        end else begin
            r_done <= 1'b0;
            if (init) begin
                r_r         <= key[127:0] & R_CLAMP;
                r_s         <= key[255:128];
                r_acc       <= '0;
                r_state     <= S_LOAD;
                r_blk_ready <= 1'b1;
                r_busy      <= 1'b0;
                r_tag_ok    <= 1'b0;
                r_tag_out   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_blk_ready <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                    S_LOAD: begin
                        if (blk_valid) begin
                            r_a         <= w_a_red;
                            r_t         <= '0;
                            r_k         <= 7'd127;
                            r_state     <= S_MUL;
                            r_blk_ready <= 1'b0;
                            r_busy      <= 1'b1;
                        end else if (fin) begin
                            r_tag_in    <= tag_in;
                            r_state     <= S_FIN;
                            r_blk_ready <= 1'b0;
                            r_busy      <= 1'b1;
                        end
                    end
                    S_MUL: begin
                        r_t <= w_t_next;
                        if (r_k == 7'd0) begin
                            r_acc       <= w_t_next[129:0];
                            r_state     <= S_LOAD;
                            r_blk_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_k <= r_k - 7'd1;
                        end
                    end
                    S_FIN: begin
                        r_tag_out   <= w_tag;
                        r_tag_ok    <= w_tag_match;
                        r_done      <= 1'b1;
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_blk_ready <= 1'b0;
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_blk_ready <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign blk_ready = r_blk_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign tag_ok    = r_tag_ok;
    assign tag_out   = r_tag_out;

endmodule

// File: tb/tb_poly1305_tag_verifier.sv
// Scoreboard bench for poly1305_tag_verifier: stimulus pushes expected
// {tag, ok, done-cycle}; a negedge monitor pops on every done pulse.
module tb_poly1305_tag_verifier;

    localparam logic [263:0] P264    = 264'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;
    localparam logic [127:0] CLAMP   = 128'h0fff_fffc_0fff_fffc_0fff_fffc_0fff_ffff;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         init;
    logic [255:0] key;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic [3:0]   blk_len;
    logic         fin;
    logic [127:0] tag_in;
    logic         busy;
    logic         done;
    logic         tag_ok;
    logic [127:0] tag_out;

    poly1305_tag_verifier dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .init      (init),
        .key       (key),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_len   (blk_len),
        .fin       (fin),
        .tag_in    (tag_in),
        .busy      (busy),
        .done      (done),
        .tag_ok    (tag_ok),
        .tag_out   (tag_out)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [127:0] tag;
        logic         ok;
        int unsigned  cyc;
    } exp_t;
    exp_t sb[$];

    // reference model state
    logic [129:0] m_acc;
    logic [127:0] m_r;
    logic [127:0] m_s;

    // RFC 8439 2.5.2 vector
    byte unsigned kb[32] = '{8'h85, 8'hd6, 8'hbe, 8'h78, 8'h57, 8'h55, 8'h6d, 8'h33,
                             8'h7f, 8'h44, 8'h52, 8'hfe, 8'h42, 8'hd5, 8'h06, 8'ha8,
                             8'h01, 8'h03, 8'h80, 8'h8a, 8'hfb, 8'h0d, 8'hb2, 8'hfd,
                             8'h4a, 8'hbf, 8'hf6, 8'haf, 8'h41, 8'h49, 8'hf5, 8'h1b};
    byte unsigned tb_b[16] = '{8'ha8, 8'h06, 8'h1d, 8'hc1, 8'h30, 8'h51, 8'h36, 8'hc6,
                               8'hc2, 8'h2b, 8'h8b, 8'haf, 8'h0c, 8'h01, 8'h27, 8'ha9};
    string        msg = "Cryptographic Forum Research Group";
    logic [255:0] rfc_key;
    logic [127:0] rfc_tag;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Plain modular arithmetic: acc = ((acc + m) * r) mod p
    task automatic model_init(input logic [255:0] k);
        m_r   = k[127:0] & CLAMP;
        m_s   = k[255:128];
        m_acc = '0;
    endtask

    task automatic model_block(input logic [127:0] data, input logic [3:0] len);
        int unsigned  nbytes;
        logic [263:0] x;
        nbytes = (len == 4'd0) ? 16 : int'(len);
        x = 264'(m_acc) + 264'(data) + (264'd1 << (8 * nbytes));
        x = (x * 264'(m_r)) % P264;
        m_acc = x[129:0];
    endtask

    function automatic logic [127:0] model_tag();
        return m_acc[127:0] + m_s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] mask_block(input logic [127:0] d, input logic [3:0] len);
        logic [127:0] m;
        if (len == 4'd0) return d;
        m = (128'd1 << (8 * int'(len))) - 128'd1;
        return d & m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!blk_ready && n < 300) begin
            tick();
            n++;
        end
        if (!blk_ready) check("ready_timeout", {127'd0, blk_ready}, 128'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic do_init(input logic [255:0] k);
        init = 1'b1;
        key  = k;
        tick();
        init = 1'b0;
        key  = {rnd128(), rnd128()};
        model_init(k);
        check("init_ready", {127'd0, blk_ready}, 128'd1);
        check("init_busy", {127'd0, busy}, 128'd0);
        check("init_tag_ok", {127'd0, tag_ok}, 128'd0);
        check("init_tag_out", tag_out, 128'd0);
    endtask

    // Accept one block, then confirm MUL lasts exactly 128 cycles with busy high
    task automatic send_block(input logic [127:0] d, input logic [3:0] len, input logic with_fin);
        int   n;
        logic busy_low;
        wait_ready();
        blk_data  = d;
        blk_len   = len;
        blk_valid = 1'b1;
        fin       = with_fin;
        tag_in    = rnd128();
        tick();
        blk_valid = 1'b0;
        fin       = 1'b0;
        blk_data  = rnd128();
        model_block(d, len);
        n        = 0;
        busy_low = 1'b0;
        while (!blk_ready && n < 400) begin
            if (!busy) busy_low = 1'b1;
            tick();
            n++;
        end
        check("mul_cycles", 128'(n), 128'd128);
        check("mul_busy_held", {127'd0, busy_low}, 128'd0);
        check("mul_busy_end", {127'd0, busy}, 128'd0);
    endtask

    task automatic do_fin(input logic [127:0] tin, input logic [127:0] exp_tag);
        exp_t e;
        int   n;
        wait_ready();
        fin    = 1'b1;
        tag_in = tin;
        tick();
        fin    = 1'b0;
        tag_in = ~tin;
        e.tag = exp_tag;
        e.ok  = (exp_tag == tin);
        e.cyc = cyc + 1;
        sb.push_back(e);
        n = 0;
        while (sb.size() != 0 && n < 8) begin
            tick();
            n++;
        end
        check("done_seen", 128'(sb.size()), 128'd0);
        check("fin_idle_ready", {127'd0, blk_ready}, 128'd0);
        check("fin_idle_busy", {127'd0, busy}, 128'd0);
    endtask

    task automatic rfc_message(input logic first_with_fin);
        logic [127:0] d;
        int unsigned  len;
        for (int unsigned b = 0; b < 3; b++) begin
            len = (b < 2) ? 16 : 2;
            d   = '0;
            for (int unsigned i = 0; i < len; i++) d[8*i +: 8] = msg[16*b + i];
            send_block(d, (len == 16) ? 4'd0 : 4'(len), (b == 0) ? first_with_fin : 1'b0);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("tag_out", tag_out, e.tag);
                check("tag_ok", {127'd0, tag_ok}, {127'd0, e.ok});
                check("done_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] k;
        logic [127:0] s_new;
        logic [127:0] t;
        logic [3:0]   len;
        int unsigned  nblk;

        for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = kb[i];
        for (int i = 0; i < 16; i++) rfc_tag[8*i +: 8] = tb_b[i];

        init = 1'b0; key = '0; blk_valid = 1'b0; blk_data = '0; blk_len = '0;
        fin = 1'b0; tag_in = '0;
        do_reset();

        check("rst_ready", {127'd0, blk_ready}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_tag_ok", {127'd0, tag_ok}, 128'd0);
        check("rst_tag_out", tag_out, 128'd0);

        // IDLE ignores blk_valid and fin
        blk_valid = 1'b1; fin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_no_ready", {127'd0, blk_ready}, 128'd0);
        end
        blk_valid = 1'b0; fin = 1'b0;

        // RFC vector, correct then corrupted tag
        do_init(rfc_key);
        rfc_message(1'b0);
        do_fin(rfc_tag, rfc_tag);

        do_init(rfc_key);
        rfc_message(1'b0);
        t = rfc_tag ^ 128'd1;
        do_fin(t, rfc_tag);

        // IDLE after FIN still ignores requests
        blk_valid = 1'b1; fin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_fin_idle", {127'd0, blk_ready}, 128'd0);
        end
        blk_valid = 1'b0; fin = 1'b0;

        // Empty message: tag = s
        do_init(rfc_key);
        do_fin(rfc_key[255:128], 128'h1bf54941aff6bf4afdb20dfb8a800301);
        do_init(rfc_key);
        do_fin(rnd128(), 128'h1bf54941aff6bf4afdb20dfb8a800301);

        // blk_valid with fin: block wins, fin dropped; vector still verifies
        do_init(rfc_key);
        rfc_message(1'b1);
        do_fin(rfc_tag, rfc_tag);

        // Abort mid-MUL with a new key; accumulator must restart from zero
        do_init(rfc_key);
        wait_ready();
        blk_data = rnd128(); blk_len = 4'd0; blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        check("abort_busy_mid", {127'd0, busy}, 128'd1);
        s_new = rnd128();
        do_init({s_new, rnd128()});
        for (int i = 0; i < 5; i++) tick();
        do_fin(s_new, s_new);
        do_init(rfc_key);
        rfc_message(1'b0);
        do_fin(rfc_tag, rfc_tag);

        // init during FIN aborts: no done, outputs cleared
        do_init(rfc_key);
        wait_ready();
        fin = 1'b1; tag_in = rfc_key[255:128];
        tick();
        fin = 1'b0; init = 1'b1; key = rfc_key;
        tick();
        init = 1'b0;
        model_init(rfc_key);
        check("finabort_tag_ok", {127'd0, tag_ok}, 128'd0);
        check("finabort_tag_out", tag_out, 128'd0);
        check("finabort_ready", {127'd0, blk_ready}, 128'd1);
        for (int i = 0; i < 4; i++) tick();

        // Reset mid-MUL: outputs go to reset values immediately
        wait_ready();
        blk_data = rnd128(); blk_len = 4'd0; blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        reset_n = 1'b0;
        #1;
        check("arst_ready", {127'd0, blk_ready}, 128'd0);
        check("arst_busy", {127'd0, busy}, 128'd0);
        check("arst_done", {127'd0, done}, 128'd0);
        check("arst_tag_ok", {127'd0, tag_ok}, 128'd0);
        check("arst_tag_out", tag_out, 128'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // r = 0: tag is s whatever the blocks are
        s_new = rnd128();
        do_init({s_new, 128'd0});
        for (int i = 0; i < 3; i++) begin
            len = 4'($urandom_range(0, 15));
            send_block(mask_block(rnd128(), len), len, 1'b0);
        end
        do_fin(s_new, s_new);

        // Random keys and messages against the arithmetic model
        for (int m = 0; m < 6; m++) begin
            k = {rnd128(), rnd128()};
            do_init(k);
            nblk = $urandom_range(0, 3);
            for (int unsigned b = 0; b < nblk; b++) begin
                len = 4'($urandom_range(0, 15));
                send_block(mask_block(rnd128(), len), len, 1'b0);
            end
            t = model_tag();
            if ($urandom_range(0, 1) == 1) t = t ^ (128'd1 << $urandom_range(0, 127));
            do_fin(t, model_tag());
        end

        for (int i = 0; i < 4; i++) tick();
        check("sb_empty", 128'(sb.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
